// File: rtl/tlul_sram_responder.sv
// ---------------------------------------------------------------------------
// Module  : tlul_sram_responder
// Brief   : TileLink-UL single-beat responder backed by a 64-bit flop array.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tlul_sram_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h0800_0000,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [2:0]  a_source,
  input  logic [31:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  input  logic        a_corrupt,
  output logic        a_ready,
  output logic        d_valid,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic [2:0]  d_source,
  output logic        d_denied,
  output logic [63:0] d_data,
  output logic        d_corrupt,
  input  logic        d_ready,
  output logic [7:0]  err_count
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         TAG_LSB  = 3 + DEPTH_LOG2;
  localparam logic [2:0] OP_PUTF  = 3'd0;
  localparam logic [2:0] OP_PUTP  = 3'd1;
  localparam logic [2:0] OP_GET   = 3'd4;
  localparam logic [2:0] OP_ACK   = 3'd0;
  localparam logic [2:0] OP_ACKD  = 3'd1;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RESP = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic                  a_fire;
  logic                  d_fire;
  logic                  is_get;
  logic                  is_put;
  logic                  out_of_window;
  logic                  misaligned;
  logic                  denied;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] idx;
  logic [63:0]           rd_word;
  logic                  unused_param;

  assign unused_param = ^a_param;

  assign a_ready = !d_valid | d_ready;
  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;

  // Request decode
  assign is_get        = (a_opcode == OP_GET);
  assign is_put        = (a_opcode == OP_PUTF) | (a_opcode == OP_PUTP);
  assign out_of_window = (a_address[31:TAG_LSB] != ADDR_BASE[31:TAG_LSB]);
  assign idx           = a_address[TAG_LSB-1:3];

  always_comb begin
    misaligned = 1'b0;
    case (a_size)
      4'd1:    misaligned = a_address[0];
      4'd2:    misaligned = |a_address[1:0];
      4'd3:    misaligned = |a_address[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign denied = out_of_window | (a_size > 4'd3) | misaligned
                | !(is_get | is_put) | (is_put & a_corrupt);
  assign wr_en  = a_fire & is_put & !denied;

  // One independent byte-lane array per mask bit; memory is deliberately unreset
  for (genvar i = 0; i < 8; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clock) begin
      if (wr_en && a_mask[i]) begin
        mem[idx] <= a_data[8*i +: 8];
      end
    end
    assign rd_word[8*i +: 8] = mem[idx];
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE: if (a_fire) state_next = STATE_RESP;
      STATE_RESP: if (d_fire && !a_fire) state_next = STATE_IDLE;
      default:    state_next = STATE_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    d_valid = (state == STATE_RESP);
  end

  assign d_param = 2'd0;

  // Response register: loads only on A fire so fields hold under backpressure
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_opcode  <= 3'd0;
      d_size    <= 4'd0;
      d_source  <= 3'd0;
      d_denied  <= 1'b0;
      d_data    <= 64'd0;
      d_corrupt <= 1'b0;
    end else if (a_fire) begin
      d_opcode  <= is_get ? OP_ACKD : OP_ACK;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= denied;
      d_data    <= (is_get && !denied) ? rd_word : 64'd0;
      d_corrupt <= is_get & denied;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= 8'd0;
    end else if (a_fire && denied && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlul_sram_responder.sv
// ---------------------------------------------------------------------------
// Module  : tb_tlul_sram_responder
// Brief   : Table-driven bench for tlul_sram_responder plus multi-cycle cases.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tlul_sram_responder;

  logic        clock;
  logic        reset_n;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [2:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        a_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [2:0]  d_source;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;
  logic        d_ready;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  tlul_sram_responder #(
    .ADDR_BASE (32'h0800_0000),
    .DEPTH_LOG2(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .a_valid  (a_valid),
    .a_opcode (a_opcode),
    .a_param  (a_param),
    .a_size   (a_size),
    .a_source (a_source),
    .a_address(a_address),
    .a_mask   (a_mask),
    .a_data   (a_data),
    .a_corrupt(a_corrupt),
    .a_ready  (a_ready),
    .d_valid  (d_valid),
    .d_opcode (d_opcode),
    .d_param  (d_param),
    .d_size   (d_size),
    .d_source (d_source),
    .d_denied (d_denied),
    .d_data   (d_data),
    .d_corrupt(d_corrupt),
    .d_ready  (d_ready),
    .err_count(err_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [2:0]  src;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
    logic [2:0]  e_op;
    logic        e_den;
    logic [63:0] e_data;
    logic        e_corr;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [3:0] size, input logic [2:0] src,
                     input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                     input logic corrupt, input logic [2:0] e_op, input logic e_den,
                     input logic [63:0] e_data, input logic e_corr, input logic [7:0] e_err);
    vec_t v;
    v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
    v.corrupt = corrupt; v.e_op = e_op; v.e_den = e_den; v.e_data = e_data;
    v.e_corr = e_corr; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] size, input logic [2:0] src,
                       input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                       input logic corrupt);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = corrupt;
  endtask

  initial begin
    logic [63:0] held_data;

    reset_n = 1'b0; a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 4'd0;
    a_source = 3'd0; a_address = 32'd0; a_mask = 8'd0; a_data = 64'd0; a_corrupt = 1'b0;
    d_ready = 1'b1;

    //   op    sz    src   addr           mask   data                    c  eop  den e_data                  ec e_err
    add(3'd0, 4'd3, 3'd2, 32'h0800_0008, 8'hFF, 64'h1122334455667788, 0, 3'd0, 0, 64'h0,                 0, 8'd0);
    add(3'd4, 4'd3, 3'd1, 32'h0800_0008, 8'h00, 64'h0,                0, 3'd1, 0, 64'h1122334455667788, 0, 8'd0);
    add(3'd1, 4'd3, 3'd3, 32'h0800_0008, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0, 3'd0, 0, 64'h0,                 0, 8'd0);
    add(3'd4, 4'd3, 3'd4, 32'h0800_0008, 8'h00, 64'h0,                0, 3'd1, 0, 64'h11223344BBBBBBBB, 0, 8'd0);
    add(3'd4, 4'd3, 3'd0, 32'h0900_0000, 8'h00, 64'h0,                0, 3'd1, 1, 64'h0,                 1, 8'd1);
    add(3'd0, 4'd4, 3'd1, 32'h0800_0010, 8'hFF, 64'h0,                0, 3'd0, 1, 64'h0,                 0, 8'd2);
    add(3'd4, 4'd2, 3'd2, 32'h0800_0002, 8'h00, 64'h0,                0, 3'd1, 1, 64'h0,                 1, 8'd3);
    add(3'd2, 4'd3, 3'd3, 32'h0800_0008, 8'hFF, 64'h0,                0, 3'd0, 1, 64'h0,                 0, 8'd4);
    add(3'd0, 4'd3, 3'd4, 32'h0800_0008, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1, 3'd0, 1, 64'h0,                 0, 8'd5);
    add(3'd4, 4'd3, 3'd5, 32'h0800_0008, 8'h00, 64'h0,                0, 3'd1, 0, 64'h11223344BBBBBBBB, 0, 8'd5);
    add(3'd0, 4'd3, 3'd6, 32'h0800_0010, 8'hFF, 64'h0,                0, 3'd0, 0, 64'h0,                 0, 8'd5);
    add(3'd1, 4'd2, 3'd7, 32'h0800_0014, 8'hF0, 64'hCAFEF00D00000000, 0, 3'd0, 0, 64'h0,                 0, 8'd5);
    add(3'd1, 4'd0, 3'd0, 32'h0800_0011, 8'h02, 64'h000000000000AB00, 0, 3'd0, 0, 64'h0,                 0, 8'd5);
    add(3'd4, 4'd3, 3'd1, 32'h0800_0010, 8'h00, 64'h0,                0, 3'd1, 0, 64'hCAFEF00D0000AB00, 0, 8'd5);
    add(3'd0, 4'd3, 3'd2, 32'h0800_0078, 8'hFF, 64'hDEADBEEF01234567, 0, 3'd0, 0, 64'h0,                 0, 8'd5);
    add(3'd4, 4'd3, 3'd3, 32'h0800_0078, 8'h00, 64'h0,                0, 3'd1, 0, 64'hDEADBEEF01234567, 0, 8'd5);
    add(3'd4, 4'd3, 3'd4, 32'h0800_0080, 8'h00, 64'h0,                0, 3'd1, 1, 64'h0,                 1, 8'd6);
    add(3'd4, 4'd1, 3'd5, 32'h0800_0009, 8'h00, 64'h0,                0, 3'd1, 1, 64'h0,                 1, 8'd7);

    // Reset state
    #3;
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Table: one request, response checked one cycle later, then drained
    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr, vecs[i].mask,
            vecs[i].data, vecs[i].corrupt);
      @(negedge clock);
      a_valid = 1'b0;
      chk($sformatf("v%0d_d_valid", i), 64'(d_valid), 64'd1);
      chk($sformatf("v%0d_d_opcode", i), 64'(d_opcode), 64'(vecs[i].e_op));
      chk($sformatf("v%0d_d_denied", i), 64'(d_denied), 64'(vecs[i].e_den));
      chk($sformatf("v%0d_d_data", i), d_data, vecs[i].e_data);
      chk($sformatf("v%0d_d_corrupt", i), 64'(d_corrupt), 64'(vecs[i].e_corr));
      chk($sformatf("v%0d_d_source", i), 64'(d_source), 64'(vecs[i].src));
      chk($sformatf("v%0d_d_size", i), 64'(d_size), 64'(vecs[i].size));
      chk($sformatf("v%0d_d_param", i), 64'(d_param), 64'd0);
      chk($sformatf("v%0d_err_count", i), 64'(err_count), 64'(vecs[i].e_err));
      @(negedge clock);
      chk($sformatf("v%0d_drained", i), 64'(d_valid), 64'd0);
    end

    // Backpressure: response held for 5 cycles, then back-to-back
    @(negedge clock);
    d_ready = 1'b0;
    drive(3'd4, 4'd3, 3'd1, 32'h0800_0008, 8'h00, 64'h0, 1'b0);
    @(negedge clock);
    drive(3'd4, 4'd3, 3'd5, 32'h0800_0010, 8'h00, 64'h0, 1'b0);
    chk("bp_d_valid", 64'(d_valid), 64'd1);
    chk("bp_d_data", d_data, 64'h11223344BBBBBBBB);
    held_data = d_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("bp_a_ready_%0d", k), 64'(a_ready), 64'd0);
      chk($sformatf("bp_hold_data_%0d", k), d_data, held_data);
      chk($sformatf("bp_hold_src_%0d", k), 64'(d_source), 64'd1);
      chk($sformatf("bp_hold_valid_%0d", k), 64'(d_valid), 64'd1);
    end
    d_ready = 1'b1;
    @(negedge clock);
    chk("b2b1_d_valid", 64'(d_valid), 64'd1);
    chk("b2b1_d_source", 64'(d_source), 64'd5);
    chk("b2b1_d_data", d_data, 64'hCAFEF00D0000AB00);
    drive(3'd4, 4'd3, 3'd6, 32'h0800_0078, 8'h00, 64'h0, 1'b0);
    @(negedge clock);
    a_valid = 1'b0;
    chk("b2b2_d_valid", 64'(d_valid), 64'd1);
    chk("b2b2_d_source", 64'(d_source), 64'd6);
    chk("b2b2_d_data", d_data, 64'hDEADBEEF01234567);
    @(negedge clock);
    chk("b2b_drained", 64'(d_valid), 64'd0);

    // Error counter saturation: 300 back-to-back denied Gets
    drive(3'd4, 4'd3, 3'd0, 32'h0900_0000, 8'h00, 64'h0, 1'b0);
    for (int k = 0; k < 300; k++) @(negedge clock);
    a_valid = 1'b0;
    chk("sat_err_count", 64'(err_count), 64'd255);
    chk("sat_d_denied", 64'(d_denied), 64'd1);
    @(negedge clock);
    chk("sat_drained", 64'(d_valid), 64'd0);

    // Reset asserted while a response is pending
    d_ready = 1'b0;
    drive(3'd4, 4'd3, 3'd2, 32'h0800_0008, 8'h00, 64'h0, 1'b0);
    @(negedge clock);
    a_valid = 1'b0;
    chk("mid_d_valid_before", 64'(d_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_d_valid_in_reset", 64'(d_valid), 64'd0);
    chk("mid_err_count_in_reset", 64'(err_count), 64'd0);
    chk("mid_a_ready_in_reset", 64'(a_ready), 64'd1);
    chk("mid_d_data_in_reset", d_data, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("post_rst_no_resp_%0d", k), 64'(d_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlul_sram_responder.md
TLUL_SRAM_RESPONDER -- requirements
Module: tlul_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, 32'h0800_0000, base address of the responder window; aligned to window size.
REQ-002 SHALL have parameter DEPTH_LOG2, 4, log2 of the number of 64-bit words; legal range 1..8.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have A-channel inputs a_valid (1), a_opcode (3), a_param (3), a_size (4), a_source (3), a_address (32), a_mask (8), a_data (64), a_corrupt (1), plus output a_ready (1).
REQ-006 SHALL have D-channel outputs d_valid (1), d_opcode (3), d_param (2), d_size (4), d_source (3), d_denied (1), d_data (64), d_corrupt (1), plus input d_ready (1).
REQ-007 SHALL have output err_count, 8, saturating count of denied responses issued.

Function
REQ-008 SHALL implement a TileLink-UL single-beat responder backed by a 2^DEPTH_LOG2 x 64-bit flop array.
REQ-009 SHALL define A fire = a_valid & a_ready and D fire = d_valid & d_ready.
REQ-010 SHALL drive a_ready = !d_valid | d_ready (combinational, one-entry response register, no A-to-D combinational path).
REQ-011 SHALL have two states: IDLE (d_valid=0) and RESP (d_valid=1); IDLE->RESP on A fire; RESP->IDLE on D fire without A fire; RESP stays RESP on simultaneous D fire and A fire, with the response register reloaded.
REQ-012 SHALL present the response exactly 1 cycle after A fire; response fields SHALL hold stable while d_valid=1 and d_ready=0.
REQ-013 SHALL copy a_source to d_source and a_size to d_size; d_param SHALL be 0.
REQ-014 SHALL accept opcodes Get (4), PutFullData (0), and PutPartialData (1); the response opcode SHALL be AccessAckData (1) for Get and AccessAck (0) otherwise, including for denied requests of those opcodes.
REQ-015 SHALL deny (d_denied=1) if any of the following holds: a_address[31:3+DEPTH_LOG2] differs from ADDR_BASE; a_size > 3; a_address is misaligned to 2^a_size; or the opcode is unsupported.
REQ-016 SHALL answer an unsupported opcode with AccessAck and d_denied=1.
REQ-017 SHALL index the word as a_address[3+DEPTH_LOG2-1:3].
REQ-018 SHALL, for an allowed Get, return the full indexed word on d_data with d_corrupt=0.
REQ-019 SHALL, for a denied Get, set d_data=0 and d_corrupt=1.
REQ-020 SHALL, for an allowed Put, write byte lane i of the indexed word from a_data only where a_mask[i]=1, on the A-fire edge.
REQ-021 SHALL, for a Put with a_corrupt=1, suppress the write and respond with d_denied=1.
REQ-022 SHALL set d_corrupt=0 and d_data=0 for AccessAck responses.
REQ-023 SHALL increment err_count by 1 on each A fire that produces a denied response; err_count SHALL saturate at 255.
REQ-024 SHALL have the read of a Get following a Put to the same word observe the written data (no write-read hazard: writes complete at A fire).
REQ-025 SHALL ignore a_param.

Reset
REQ-026 SHALL, while reset_n=0, force d_valid=0 and err_count=0, hold all other D outputs at 0, and therefore drive a_ready=1 after reset.
REQ-027 SHALL discard a pending response if reset asserts mid-transaction; no response SHALL be issued for it after release.
REQ-028 SHALL leave memory contents unreset; reads before any write return unspecified data.

Verification
REQ-029 SHALL pass: PutFull addr 0x0800_0008, data 0x1122334455667788, mask 0xFF, source 2, then Get same address -> AccessAck(src 2); next AccessAckData d_data=0x1122334455667788, denied=0, corrupt=0.
REQ-030 SHALL pass: PutPartial mask 0x0F, data 0xAAAAAAAA_BBBBBBBB to that word, then Get -> d_data=0x11223344_BBBBBBBB.
REQ-031 SHALL pass: Get addr 0x0900_0000 -> AccessAckData denied=1, corrupt=1, data=0; err_count=1.
REQ-032 SHALL pass: d_ready held 0 for 5 cycles with a pending response -> a_ready=0, D fields stable; with d_ready=1 and a_valid=1 in the same cycle -> back-to-back responses, one per cycle.
REQ-033 SHALL pass: Put with a_corrupt=1 -> AccessAck denied=1, word unchanged on a subsequent Get; 300 denied requests -> err_count=255.
REQ-034 SHALL pass: reset_n pulsed low while d_valid=1 -> d_valid=0 immediately; no response after release.
